// File: rtl/writeback_arbiter_if.sv
// Request, register-file write and bypass-lookup bundle of the writeback arbiter.
// master drives requests and lookups; slave is the arbiter.
interface writeback_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] look_reg;
  logic              look_hit;
  logic [DATA_W-1:0] look_data;
  logic [CW-1:0]     pending;
  logic              idle;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, look_reg,
    input  alu_ready, mem_ready, wr_en, wr_reg, wr_data, look_hit, look_data, pending, idle
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, look_reg,
    output alu_ready, mem_ready, wr_en, wr_reg, wr_data, look_hit, look_data, pending, idle
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and load writebacks into one register-file write port through an in-order queue; 2-edge latency,
// ready from free slots (mem first, stalls when full); optional tail coalescing under WB_COALESCE_EN.
module writeback_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic               clock,
  input logic               reset,
  writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PW-1:0]     head, tail, last, alu_slot, idx;
  logic [CW-1:0]     count, count_nxt, free;
  logic              mem_push, alu_push, mem_co, alu_co, mem_enq, alu_enq, pop;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  assign free = CW'(DEPTH) - count;
  assign last = tail - PW'(1);

  // A register-0 load never takes a slot, so it does not block the ALU at free==1.
  assign bus.mem_ready = !reset && (free != '0);
  assign bus.alu_ready = !reset && ((free >= CW'(2)) ||
                                    ((free == CW'(1)) && !(bus.mem_valid && (bus.mem_reg != '0))));

  assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_reg != '0);
  assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_reg != '0);

`ifdef WB_COALESCE_EN
  // count>=2 keeps the tail entry clear of the entry being drained this edge.
  assign mem_co = mem_push && (count >= CW'(2)) && (bus.mem_reg == q_reg[last]);
  assign alu_co = alu_push && (count >= CW'(2)) &&
                  (bus.alu_reg == (mem_enq ? bus.mem_reg : q_reg[last]));
`else
  assign mem_co = 1'b0;
  assign alu_co = 1'b0;
`endif

  assign mem_enq  = mem_push && !mem_co;
  assign alu_enq  = alu_push && !alu_co;
  assign alu_slot = alu_co ? (mem_enq ? tail : last) : (mem_enq ? tail + PW'(1) : tail);
  assign pop      = (count != '0);
  assign count_nxt = count + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_reg  <= '0;
      bus.wr_data <= '0;
    end else begin
      count     <= count_nxt;
      head      <= head + PW'(pop);
      tail      <= tail + PW'(mem_enq) + PW'(alu_enq);
      bus.wr_en <= pop;
      if (pop) begin
        bus.wr_reg  <= q_reg[head];
        bus.wr_data <= q_data[head];
      end
    end
  end

  // Entry storage is not reset; count alone decides visibility.
  always_ff @(posedge clock) begin
    if (mem_enq) begin
      q_reg[tail]  <= bus.mem_reg;
      q_data[tail] <= bus.mem_data;
    end else if (mem_co) begin
      q_data[last] <= bus.mem_data;
    end
    if (alu_push) begin
      q_reg[alu_slot]  <= bus.alu_reg;
      q_data[alu_slot] <= bus.alu_data;
    end
  end

  // Walk oldest to youngest so the youngest match wins; the output register is the oldest candidate.
  always_comb begin
    hit      = bus.wr_en && (bus.wr_reg == bus.look_reg);
    hit_data = hit ? bus.wr_data : '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (q_reg[idx] == bus.look_reg)) begin
        hit      = 1'b1;
        hit_data = q_data[idx];
      end
    end
    if (bus.look_reg == '0) begin
      hit      = 1'b0;
      hit_data = '0;
    end
  end

  assign bus.look_hit  = hit;
  assign bus.look_data = hit_data;
  assign bus.pending   = count;
  assign bus.idle      = (count == '0) && !bus.wr_en;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed table, hand sequences, then random traffic against a queue model.
module tb_writeback_arbiter;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef WB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  writeback_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic [4:0]  lr;
    logic        e_mrdy;
    logic        e_ardy;
    logic        e_wen;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    int          e_pend;
    logic        e_hit;
    logic [31:0] e_ldata;
    logic        e_idle;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  vec_t        tbl[$];
  ent_t        mq[$];
  logic        oen;
  logic [4:0]  oreg;
  logic [31:0] odata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic [4:0] lr);
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
    bus.look_reg  = lr;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_row(input vec_t v, input int k);
    drive(v.mv, v.mr, v.md, v.av, v.ar, v.ad, v.lr);
    #1;
    chk($sformatf("row%0d_mem_ready", k), 64'(bus.mem_ready), 64'(v.e_mrdy));
    chk($sformatf("row%0d_alu_ready", k), 64'(bus.alu_ready), 64'(v.e_ardy));
    chk($sformatf("row%0d_wr_en", k), 64'(bus.wr_en), 64'(v.e_wen));
    if (v.e_wen) begin
      chk($sformatf("row%0d_wr_reg", k), 64'(bus.wr_reg), 64'(v.e_wreg));
      chk($sformatf("row%0d_wr_data", k), 64'(bus.wr_data), 64'(v.e_wdata));
    end
    chk($sformatf("row%0d_pending", k), 64'(bus.pending), 64'(v.e_pend));
    chk($sformatf("row%0d_look_hit", k), 64'(bus.look_hit), 64'(v.e_hit));
    chk($sformatf("row%0d_look_data", k), 64'(bus.look_data), 64'(v.e_ldata));
    chk($sformatf("row%0d_idle", k), 64'(bus.idle), 64'(v.e_idle));
    tick();
  endtask

  function automatic void model_push(input logic [4:0] r, input logic [31:0] d, input int pre_n);
    ent_t e;
    if (r == 5'd0) return;
    if (COALESCE && pre_n >= 2 && mq.size() > 0 && mq[mq.size()-1].r == r) begin
      e = mq[mq.size()-1];
      e.d = d;
      mq[mq.size()-1] = e;
      return;
    end
    e.r = r;
    e.d = d;
    mq.push_back(e);
  endfunction

  task automatic rand_cycle(input int it, input bit force_rst);
    logic        mv, av, rst, e_mrdy, e_ardy, e_hit;
    logic [4:0]  mr, ar, lr;
    logic [31:0] md, ad, e_ld;
    int          n, free;
    rst = force_rst || ($urandom_range(0, 59) == 0);
    mv  = ($urandom_range(0, 3) != 0);
    av  = ($urandom_range(0, 3) != 0);
    mr  = 5'($urandom_range(0, 7));
    ar  = 5'($urandom_range(0, 7));
    lr  = 5'($urandom_range(0, 7));
    md  = $urandom;
    ad  = $urandom;
    reset = rst;
    drive(mv, mr, md, av, ar, ad, lr);
    #1;
    n    = mq.size();
    free = DEPTH - n;
    e_mrdy = !rst && (free >= 1);
    e_ardy = !rst && ((free >= 2) || (free == 1 && !(mv && mr != 5'd0)));
    e_hit = 1'b0;
    e_ld  = '0;
    if (lr != 5'd0) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!e_hit && mq[i].r == lr) begin
          e_hit = 1'b1;
          e_ld  = mq[i].d;
        end
      end
      if (!e_hit && oen && oreg == lr) begin
        e_hit = 1'b1;
        e_ld  = odata;
      end
    end
    chk($sformatf("rnd%0d_mem_ready", it), 64'(bus.mem_ready), 64'(e_mrdy));
    chk($sformatf("rnd%0d_alu_ready", it), 64'(bus.alu_ready), 64'(e_ardy));
    chk($sformatf("rnd%0d_wr_en", it), 64'(bus.wr_en), 64'(oen));
    if (oen) begin
      chk($sformatf("rnd%0d_wr_reg", it), 64'(bus.wr_reg), 64'(oreg));
      chk($sformatf("rnd%0d_wr_data", it), 64'(bus.wr_data), 64'(odata));
    end
    chk($sformatf("rnd%0d_pending", it), 64'(bus.pending), 64'(n));
    chk($sformatf("rnd%0d_idle", it), 64'(bus.idle), 64'((n == 0) && !oen));
    chk($sformatf("rnd%0d_look_hit", it), 64'(bus.look_hit), 64'(e_hit));
    chk($sformatf("rnd%0d_look_data", it), 64'(bus.look_data), 64'(e_ld));
    @(posedge clock);
    if (rst) begin
      mq.delete();
      oen = 1'b0;
    end else begin
      oen = (n > 0);
      if (n > 0) begin
        oreg  = mq[0].r;
        odata = mq[0].d;
        void'(mq.pop_front());
      end
      if (mv && e_mrdy) model_push(mr, md, n);
      if (av && e_ardy) model_push(ar, ad, n);
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    oen = 1'b0; oreg = '0; odata = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // single ALU write, exactly two edges to wr_en
    tbl.push_back(vec_t'{0,0,0, 1,3,32'hDEADBEEF, 3, 1,1,0,0,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 3, 1,1,0,0,0,1,1,32'hDEADBEEF,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 3, 1,1,1,3,32'hDEADBEEF,0,1,32'hDEADBEEF,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 3, 1,1,0,0,0,0,0,0,1});
    // simultaneous mem+alu: mem written first
    tbl.push_back(vec_t'{1,5,32'h11, 1,6,32'h22, 6, 1,1,0,0,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 6, 1,1,0,0,0,2,1,32'h22,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 5, 1,1,1,5,32'h11,1,1,32'h11,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 6, 1,1,1,6,32'h22,0,1,32'h22,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 6, 1,1,0,0,0,0,0,0,1});
    // back-to-back pairs: at count 3 only mem is accepted
    tbl.push_back(vec_t'{1,1,32'hA1, 1,2,32'hA2, 0, 1,1,0,0,0,0,0,0,1});
    tbl.push_back(vec_t'{1,3,32'hB3, 1,4,32'hB4, 0, 1,1,0,0,0,2,0,0,0});
    tbl.push_back(vec_t'{1,5,32'hC5, 1,6,32'hC6, 4, 1,0,1,1,32'hA1,3,1,32'hB4,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 1, 1,1,1,2,32'hA2,3,0,0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 5, 1,1,1,3,32'hB3,2,1,32'hC5,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 0, 1,1,1,4,32'hB4,1,0,0,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 5, 1,1,1,5,32'hC5,0,1,32'hC5,0});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 5, 1,1,0,0,0,0,0,0,1});
    // register 0 accepted but dropped
    tbl.push_back(vec_t'{0,0,0, 1,0,32'h55, 0, 1,1,0,0,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 0, 1,1,0,0,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0, 0,0,0, 0, 1,1,0,0,0,0,0,0,1});

    @(negedge clock);
    #1;
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'(0));
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("rst_pending", 64'(bus.pending), 64'(0));
    chk("rst_wr_en", 64'(bus.wr_en), 64'(0));
    chk("rst_idle", 64'(bus.idle), 64'(1));

    for (int k = 0; k < tbl.size(); k++) apply_row(tbl[k], k);

    // bypass: youngest of two queued writes to reg 7 wins
    drive(1, 7, 32'h1, 1, 7, 32'h2, 7);
    #1;
    chk("byp_both_ready", 64'({bus.mem_ready, bus.alu_ready}), 64'(2'b11));
    chk("byp_incoming_not_seen", 64'(bus.look_hit), 64'(0));
    tick();
    drive(0, 0, 0, 0, 0, 0, 7);
    #1;
    chk("byp_pending2", 64'(bus.pending), 64'(2));
    chk("byp_hit_q", 64'({bus.look_hit, bus.look_data}), {31'd0, 1'b1, 32'h2});
    tick();
    #1;
    chk("byp_hit_q_over_out", 64'({bus.look_hit, bus.look_data}), {31'd0, 1'b1, 32'h2});
    tick();
    #1;
    chk("byp_wr_data", 64'({bus.wr_en, bus.wr_data}), {31'd0, 1'b1, 32'h2});
    chk("byp_hit_out", 64'({bus.look_hit, bus.look_data}), {31'd0, 1'b1, 32'h2});
    tick();
    #1;
    chk("byp_miss_after_drain", 64'({bus.look_hit, bus.look_data}), 64'(0));

    // reset with three pending writes
    drive(1, 9, 32'h90, 1, 10, 32'hA0, 0);
    tick();
    drive(1, 11, 32'hB0, 1, 12, 32'hC0, 0);
    tick();
    reset = 1'b1;
    drive(1, 13, 32'hD0, 1, 14, 32'hE0, 0);
    #1;
    chk("mrst_pending3", 64'(bus.pending), 64'(3));
    chk("mrst_ready_low", 64'({bus.mem_ready, bus.alu_ready}), 64'(0));
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mrst_pending0", 64'(bus.pending), 64'(0));
    chk("mrst_wr_en_a", 64'(bus.wr_en), 64'(0));
    chk("mrst_idle", 64'(bus.idle), 64'(1));
    tick();
    #1;
    chk("mrst_wr_en_b", 64'(bus.wr_en), 64'(0));

    for (int it = 0; it < 600; it++) rand_cycle(it, it == 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writer side of the register-file write port: merges writeback requests from the ALU path and the load/memory path into the single write port (enable, register index, data), one write per cycle.
- Buffers pending writes in a small in-order queue.
- Exposes a bypass lookup so decode reads see values still queued or in flight.
- Sits between the execute/memory stages and the register bank.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request present
- alu_ready  out  1  ALU request accepted this cycle when alu_valid=1
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load writeback request present
- mem_ready  out  1  load request accepted this cycle when mem_valid=1
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- wr_en  out  1  register-file write enable (registered)
- wr_reg  out  ADDR_W  register-file write index (registered)
- wr_data  out  DATA_W  register-file write data (registered)
- look_reg  in  ADDR_W  register being read by decode
- look_hit  out  1  a pending or in-flight write targets look_reg
- look_data  out  DATA_W  newest pending value for look_reg
- pending  out  clog2(DEPTH)+1  queued entry count
- idle  out  1  queue empty and wr_en=0

Behaviour:
- Reset (clock edge with reset=1): count=0, head/tail=0, wr_en=0, wr_reg=0, wr_data=0. alu_ready=mem_ready=0 while reset=1. Entries not cleared but invisible (count=0). Reset mid-operation discards all queued writes; no write issues on the reset cycle or the cycle after.
- Handshake: transfer occurs on an edge where valid&ready=1. ready is combinational from count before the edge; pop credit is not used (free = DEPTH-count).
- Priority: mem before alu (load is older).
  - free>=2: both ready=1. If both transfer, mem enqueues first, alu second.
  - free==1: mem_ready=1. alu_ready=1 only if mem_valid=0.
  - free==0: both ready=0.
- Register 0: request with reg==0 is accepted (ready per rules above) but not enqueued and never written. It consumes no slot and is ignored when computing the other source's slot.
- Drain: on each edge with count>0 (pre-edge), head entry moves to wr_reg/wr_data, wr_en=1, head advances. Otherwise wr_en=0. Max one write per cycle. Push and pop on the same edge are allowed; count' = count + pushes - pop.
- Latency: request accepted at edge N into an empty queue -> wr_en=1 during cycle after edge N+1 (two edges). Sustained throughput is 1 write/cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- Bypass (combinational): search order is youngest queue entry, then older entries toward head, then the output register if wr_en=1. First match gives look_hit=1, look_data=its data. look_reg==0 -> look_hit=0, look_data=0. No match -> look_hit=0, look_data=0. Incoming same-cycle requests are not searched.
- pending=count. idle=(count==0)&~wr_en.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - If an accepted request targets the same register as the current tail entry and pre-edge count>=2, it overwrites that entry's data instead of enqueuing; count is unchanged.
  - With both sources transferring, mem is applied first; alu then compares against the resulting tail.
  - Coalescing still requires ready per the normal rules.
- Undefined: every accepted nonzero-register request occupies its own slot, and writes issue in order.

Test Plan:
- Single ALU write: alu_reg=3, data=0xDEADBEEF, one cycle -> wr_en=1, wr_reg=3, wr_data=0xDEADBEEF exactly two edges later, then idle=1.
- Simultaneous: mem(reg 5, 0x11) + alu(reg 6, 0x22) on empty queue -> both ready. Writes reg 5 then reg 6 on consecutive cycles.
- Fill to DEPTH=4 with drain stalled by back-to-back pushes -> with count=3 and both valid, only mem accepted. At count=4, both ready=0. Writes exit in acceptance order.
- Register 0: alu_reg=0, data=0x55 -> alu_ready=1, pending stays 0, no wr_en.
- Bypass: queue reg 7=0x1 then reg 7=0x2, look_reg=7 -> look_hit=1, look_data=0x2. After both drain and wr_en=0 -> look_hit=0.
- Reset with 3 pending -> after reset edge, pending=0, wr_en=0 on the next cycles, ready=0 during reset.
